// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Types and constants shared by the decode logic and the
//                pipeline hazard controller: FSM state encoding and RV32
//                major opcode values.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Hazard controller sequencing states; the values are visible on the
    // ctrl_state debug output, so the encoding is fixed.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_MEM_WAIT = 2'd2
    } ctrl_state_e;

    // RV32 major opcodes (inst[6:0]) shared with decode.
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

    // funct7 value that selects the M extension within c_OPC_OP.
    localparam logic [6:0] c_FUNCT7_MULDIV = 7'b0000001;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Bundle between the pipeline datapath and the hazard
//                controller. The pipeline side (master) reports hazard
//                events; the controller (slave) returns stall/flush strobes.
//                Define HAZARD_PERF_CNT_EN to add the performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if;

    // Events reported by the pipeline
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_ex_rd;
    logic       id_ex_memRead;
    logic       mispredict;
    logic       mdu_start;
    logic       mdu_done;
    logic       dmem_req;
    logic       dmem_ack;

    // Register controls returned by the controller
    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_stall;
    logic       id_ex_flush;
    logic       ex_mem_stall;
    logic       ex_mem_flush;
    logic       mdu_timeout_err;
    logic [1:0] ctrl_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_bubbles;
    logic [31:0] perf_flushes;
`endif

    modport master (
`ifdef HAZARD_PERF_CNT_EN
        input  perf_stall_cycles, perf_bubbles, perf_flushes,
`endif
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd,
               id_ex_memRead, mispredict, mdu_start, mdu_done,
               dmem_req, dmem_ack,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall,
               id_ex_flush, ex_mem_stall, ex_mem_flush,
               mdu_timeout_err, ctrl_state
    );

    modport slave (
`ifdef HAZARD_PERF_CNT_EN
        output perf_stall_cycles, perf_bubbles, perf_flushes,
`endif
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd,
               id_ex_memRead, mispredict, mdu_start, mdu_done,
               dmem_req, dmem_ack,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall,
               id_ex_flush, ex_mem_stall, ex_mem_flush,
               mdu_timeout_err, ctrl_state
    );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use comparator. Flags when the
//                instruction in ID reads a register that the load in EX
//                has not yet produced. x0 never creates a dependency.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_detect (
    input  wire logic [4:0] i_id_rs1,
    input  wire logic [4:0] i_id_rs2,
    input  wire logic       i_id_uses_rs1,
    input  wire logic       i_id_uses_rs2,
    input  wire logic [4:0] i_ex_rd,
    input  wire logic       i_ex_mem_read,
    output      logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // Per-operand match against the in-flight load destination
    always_comb begin
        w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
        w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
        o_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush scheduler for the 5-stage RV32 pipeline.
//                Arbitrates load-use bubbles, mispredict flushes, multi-cycle
//                MDU holds (with timeout) and data-memory wait states.
//                Outputs are combinational from state and inputs and forced
//                low while rst_n is asserted.
//                Optional: define HAZARD_PERF_CNT_EN for perf counters.
//                TMR_W must satisfy 2**TMR_W > MDU_TIMEOUT.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int TMR_W       = 7
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [TMR_W-1:0] c_TMO     = TMR_W'(MDU_TIMEOUT);
    localparam logic [TMR_W-1:0] c_TMR_ONE = TMR_W'(1);
    localparam logic [TMR_W-1:0] c_TMR_MAX = {TMR_W{1'b1}};

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_mp_pend;
    logic             w_mp_pend_nxt;

    logic             w_load_use;
    logic             w_bubble;
    logic             w_pc_stall;
    logic             w_if_id_stall;
    logic             w_if_id_flush;
    logic             w_id_ex_stall;
    logic             w_id_ex_flush;
    logic             w_ex_mem_stall;
    logic             w_ex_mem_flush;

    hazard_detect u_hazard_detect (
        .i_id_rs1      (bus.id_rs1),
        .i_id_rs2      (bus.id_rs2),
        .i_id_uses_rs1 (bus.id_uses_rs1),
        .i_id_uses_rs2 (bus.id_uses_rs2),
        .i_ex_rd       (bus.id_ex_rd),
        .i_ex_mem_read (bus.id_ex_memRead),
        .o_load_use    (w_load_use)
    );

    // State, wait timer, sticky timeout error and pending-mispredict flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_timer   <= '0;
            r_err     <= 1'b0;
            r_mp_pend <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_err     <= w_err_nxt;
            r_mp_pend <= w_mp_pend_nxt;
        end
    end

    // Next-state and stall/flush decode; RUN arbitrates events by priority
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_err_nxt      = r_err;
        w_mp_pend_nxt  = r_mp_pend;
        w_bubble       = 1'b0;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_stall = 1'b0;
        w_ex_mem_flush = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (bus.dmem_req && !bus.dmem_ack) begin
                    // Freeze the whole pipe; a branch resolving now must
                    // still redirect once memory releases.
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_stall  = 1'b1;
                    w_ex_mem_stall = 1'b1;
                    w_mp_pend_nxt  = bus.mispredict;
                    w_state_nxt    = ST_MEM_WAIT;
                end else if (bus.mispredict) begin
                    // The ID instruction is squashed, so any load-use on
                    // it is irrelevant.
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (bus.mdu_start) begin
                    // A single-cycle MDU op completes without holding.
                    if (!bus.mdu_done) begin
                        w_pc_stall     = 1'b1;
                        w_if_id_stall  = 1'b1;
                        w_id_ex_stall  = 1'b1;
                        w_ex_mem_flush = 1'b1;
                        w_timer_nxt    = c_TMR_ONE;
                        w_state_nxt    = ST_MDU_WAIT;
                    end
                end else if (w_load_use) begin
                    // One bubble: the load leaves EX next cycle, clearing
                    // the dependency.
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_bubble      = 1'b1;
                end
            end

            ST_MDU_WAIT: begin
                if (bus.mdu_done) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_RUN;
                end else if (r_timer == c_TMO) begin
                    // Hung MDU: release the pipe anyway and latch the error.
                    w_err_nxt   = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_stall  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    if (r_timer != c_TMR_MAX) begin
                        w_timer_nxt = r_timer + c_TMR_ONE;
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (bus.dmem_ack) begin
                    // Apply any redirect that arrived during the wait.
                    w_if_id_flush = r_mp_pend || bus.mispredict;
                    w_id_ex_flush = r_mp_pend || bus.mispredict;
                    w_mp_pend_nxt = 1'b0;
                    w_state_nxt   = ST_RUN;
                end else begin
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_stall  = 1'b1;
                    w_ex_mem_stall = 1'b1;
                    w_mp_pend_nxt  = r_mp_pend || bus.mispredict;
                end
            end

            default: begin
                w_timer_nxt   = '0;
                w_mp_pend_nxt = 1'b0;
                w_state_nxt   = ST_RUN;
            end
        endcase
    end

    // Outputs are held low for the whole reset window
    assign bus.pc_stall        = rst_n & w_pc_stall;
    assign bus.if_id_stall     = rst_n & w_if_id_stall;
    assign bus.if_id_flush     = rst_n & w_if_id_flush;
    assign bus.id_ex_stall     = rst_n & w_id_ex_stall;
    assign bus.id_ex_flush     = rst_n & w_id_ex_flush;
    assign bus.ex_mem_stall    = rst_n & w_ex_mem_stall;
    assign bus.ex_mem_flush    = rst_n & w_ex_mem_flush;
    assign bus.mdu_timeout_err = r_err;
    assign bus.ctrl_state      = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_bubble;
    logic [31:0] r_perf_flush;

    // Free-running event counters, wrapping modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
            r_perf_flush  <= '0;
        end else begin
            if (w_pc_stall)    r_perf_stall  <= r_perf_stall + 32'd1;
            if (w_bubble)      r_perf_bubble <= r_perf_bubble + 32'd1;
            if (w_if_id_flush) r_perf_flush  <= r_perf_flush + 32'd1;
        end
    end

    assign bus.perf_stall_cycles = r_perf_stall;
    assign bus.perf_bubbles      = r_perf_bubble;
    assign bus.perf_flushes      = r_perf_flush;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    // Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
    //                       id_ex_flush, ex_mem_stall, ex_mem_flush}
    localparam logic [6:0] c_NONE = 7'b0000000;
    localparam logic [6:0] c_LU   = 7'b1100100;
    localparam logic [6:0] c_MP   = 7'b0010100;
    localparam logic [6:0] c_MDU  = 7'b1101001;
    localparam logic [6:0] c_MEM  = 7'b1101010;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    pipe_hazard_ctrl_if bus_if ();

    pipe_hazard_ctrl #(
        .MDU_TIMEOUT (64),
        .TMR_W       (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    logic [6:0] outs;
    assign outs = {bus_if.pc_stall, bus_if.if_id_stall, bus_if.if_id_flush,
                   bus_if.id_ex_stall, bus_if.id_ex_flush,
                   bus_if.ex_mem_stall, bus_if.ex_mem_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus_if.id_rs1        = 5'd0;
        bus_if.id_rs2        = 5'd0;
        bus_if.id_uses_rs1   = 1'b0;
        bus_if.id_uses_rs2   = 1'b0;
        bus_if.id_ex_rd      = 5'd0;
        bus_if.id_ex_memRead = 1'b0;
        bus_if.mispredict    = 1'b0;
        bus_if.mdu_start     = 1'b0;
        bus_if.mdu_done      = 1'b0;
        bus_if.dmem_req      = 1'b0;
        bus_if.dmem_ack      = 1'b0;
    endtask

    // Move to the sampling point of the current cycle
    task automatic sample();
        @(negedge clk);
    endtask

    // Move to just after the next active edge, where inputs change
    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        idle();

        // ---- reset: outputs low even with an active request ----
        rst_n = 1'b0;
        bus_if.dmem_req = 1'b1;
        bus_if.mispredict = 1'b1;
        #12;
        chk("reset_outs", 32'(outs), 32'(c_NONE));
        chk("reset_state", 32'(bus_if.ctrl_state), 32'd0);
        chk("reset_err", 32'(bus_if.mdu_timeout_err), 32'd0);
        idle();
        advance();
        rst_n = 1'b1;
        sample();
        chk("idle_outs", 32'(outs), 32'(c_NONE));

        // ---- load-use on rs1 ----
        advance();
        bus_if.id_ex_memRead = 1'b1; bus_if.id_ex_rd = 5'd5;
        bus_if.id_uses_rs1 = 1'b1; bus_if.id_rs1 = 5'd5;
        sample();
        chk("lu_rs1_outs", 32'(outs), 32'(c_LU));
        chk("lu_rs1_state", 32'(bus_if.ctrl_state), 32'd0);
        advance();
        bus_if.id_ex_memRead = 1'b0; bus_if.id_ex_rd = 5'd0;
        sample();
        chk("lu_after_bubble", 32'(outs), 32'(c_NONE));

        // ---- load to x0: no hazard ----
        advance();
        bus_if.id_ex_memRead = 1'b1; bus_if.id_ex_rd = 5'd0; bus_if.id_rs1 = 5'd0;
        sample();
        chk("lu_x0", 32'(outs), 32'(c_NONE));

        // ---- rs2 match, then rs2 not used ----
        advance();
        idle();
        bus_if.id_ex_memRead = 1'b1; bus_if.id_ex_rd = 5'd7;
        bus_if.id_uses_rs2 = 1'b1; bus_if.id_rs2 = 5'd7;
        sample();
        chk("lu_rs2", 32'(outs), 32'(c_LU));
        advance();
        bus_if.id_uses_rs2 = 1'b0;
        sample();
        chk("lu_rs2_unused", 32'(outs), 32'(c_NONE));

        // ---- mispredict with simultaneous load-use ----
        advance();
        bus_if.id_uses_rs2 = 1'b1;
        bus_if.mispredict = 1'b1;
        sample();
        chk("mp_lu_outs", 32'(outs), 32'(c_MP));
        advance();
        idle();
        sample();
        chk("mp_state", 32'(bus_if.ctrl_state), 32'd0);

        // ---- MDU op, done after 10 cycles ----
        advance();
        bus_if.mdu_start = 1'b1;
        sample();
        chk("mdu_c0", 32'(outs), 32'(c_MDU));
        for (int k = 1; k < 10; k++) begin
            advance();
            idle();
            if (k == 4) begin
                // mispredict and load-use are ignored while waiting
                bus_if.mispredict = 1'b1;
                bus_if.id_ex_memRead = 1'b1; bus_if.id_ex_rd = 5'd3;
                bus_if.id_uses_rs1 = 1'b1; bus_if.id_rs1 = 5'd3;
            end
            sample();
            chk($sformatf("mdu_c%0d", k), 32'(outs), 32'(c_MDU));
            chk($sformatf("mdu_st%0d", k), 32'(bus_if.ctrl_state), 32'd1);
        end
        advance();
        idle();
        bus_if.mdu_done = 1'b1;
        sample();
        chk("mdu_done_outs", 32'(outs), 32'(c_NONE));
        advance();
        idle();
        sample();
        chk("mdu_back_run", 32'(bus_if.ctrl_state), 32'd0);
        chk("mdu_no_err", 32'(bus_if.mdu_timeout_err), 32'd0);

        // ---- single-cycle MDU op ----
        advance();
        bus_if.mdu_start = 1'b1; bus_if.mdu_done = 1'b1;
        sample();
        chk("mdu_1cyc_outs", 32'(outs), 32'(c_NONE));
        advance();
        idle();
        sample();
        chk("mdu_1cyc_state", 32'(bus_if.ctrl_state), 32'd0);

        // ---- MDU timeout: 64 stalled cycles, release on cycle 64 ----
        advance();
        bus_if.mdu_start = 1'b1;
        sample();
        chk("tmo_c0", 32'(outs), 32'(c_MDU));
        for (int k = 1; k < 64; k++) begin
            advance();
            idle();
            sample();
            chk($sformatf("tmo_c%0d", k), 32'(outs), 32'(c_MDU));
        end
        advance();
        sample();
        chk("tmo_release", 32'(outs), 32'(c_NONE));
        chk("tmo_err_pre", 32'(bus_if.mdu_timeout_err), 32'd0);
        advance();
        sample();
        chk("tmo_state", 32'(bus_if.ctrl_state), 32'd0);
        chk("tmo_err_set", 32'(bus_if.mdu_timeout_err), 32'd1);
        advance();
        advance();
        sample();
        chk("tmo_err_sticky", 32'(bus_if.mdu_timeout_err), 32'd1);

        // ---- memory wait 3 cycles, mispredict in cycle 2 ----
        advance();
        bus_if.dmem_req = 1'b1;
        sample();
        chk("mem_c0", 32'(outs), 32'(c_MEM));
        advance();
        sample();
        chk("mem_c1", 32'(outs), 32'(c_MEM));
        chk("mem_st1", 32'(bus_if.ctrl_state), 32'd2);
        advance();
        bus_if.mispredict = 1'b1;
        sample();
        chk("mem_c2_mp", 32'(outs), 32'(c_MEM));
        advance();
        bus_if.mispredict = 1'b0;
        bus_if.dmem_ack = 1'b1;
        sample();
        chk("mem_ack_flush", 32'(outs), 32'(c_MP));
        advance();
        idle();
        sample();
        chk("mem_after", 32'(outs), 32'(c_NONE));
        chk("mem_state_run", 32'(bus_if.ctrl_state), 32'd0);
        chk("mem_err_sticky", 32'(bus_if.mdu_timeout_err), 32'd1);

        // ---- memory wait without mispredict: no flush on release ----
        advance();
        bus_if.dmem_req = 1'b1;
        sample();
        advance();
        bus_if.dmem_ack = 1'b1;
        sample();
        chk("mem_ack_noflush", 32'(outs), 32'(c_NONE));

        // ---- async reset in the middle of an MDU wait ----
        advance();
        idle();
        bus_if.mdu_start = 1'b1;
        advance();
        bus_if.mdu_start = 1'b0;
        advance();
        sample();
        chk("rst_mid_pre", 32'(bus_if.ctrl_state), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 32'(outs), 32'(c_NONE));
        chk("rst_mid_state", 32'(bus_if.ctrl_state), 32'd0);
        chk("rst_mid_err", 32'(bus_if.mdu_timeout_err), 32'd0);
        advance();
        rst_n = 1'b1;
        sample();
        chk("rst_post_outs", 32'(outs), 32'(c_NONE));
        chk("rst_post_state", 32'(bus_if.ctrl_state), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
